// File: rtl/pipe_ctrl_decoder.sv
// Registered main-control decoder for the pipelined MIPS core: ID-stage decode into the
// ID/EX control register, load-use hazard detection, bubble insertion and a stall counter.
module pipe_ctrl_decoder #(
  parameter int ALU_OP_W = 4,
  parameter int BTYPE_W  = 2,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         instr_i,
  input  logic                instr_vld_i,
  input  logic                flush_i,
  input  logic                ex_memread_i,
  input  logic [REG_W-1:0]    ex_rt_i,
  output logic                stall_o,
  output logic                vld_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alusrc_o,
  output logic                regdst_o,
  output logic                regwrite_o,
  output logic                branch_o,
  output logic                memtoreg_o,
  output logic                memread_o,
  output logic                memwrite_o,
  output logic                jump_o,
  output logic                jal_o,
  output logic                jr_o,
  output logic [BTYPE_W-1:0]  btype_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_BGEZ = 6'd1;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_BGT  = 6'd7;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LUI  = 6'd15;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [5:0] FUNCT_JR = 6'd8;

  localparam logic [1:0] BT_EQ  = 2'd0;
  localparam logic [1:0] BT_GT  = 2'd1;
  localparam logic [1:0] BT_GEZ = 2'd2;
  localparam logic [1:0] BT_NE  = 2'd3;

  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic             w_unused_bits;

  assign w_op          = instr_i[31:26];
  assign w_funct       = instr_i[5:0];
  assign w_rs          = REG_W'(instr_i[25:21]);
  assign w_rt          = REG_W'(instr_i[20:16]);
  assign w_unused_bits = ^instr_i[15:6];

  logic [3:0] w_alu_code;
  logic [1:0] w_bt_code;
  logic       w_alusrc;
  logic       w_regdst;
  logic       w_regwrite;
  logic       w_branch;
  logic       w_memtoreg;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_jump;
  logic       w_jal;
  logic       w_jr;
  logic       w_illegal;
  logic       w_rs_used;
  logic       w_rt_used;

  always_comb begin
    w_alu_code = 4'd0;
    w_bt_code  = BT_EQ;
    w_alusrc   = 1'b0;
    w_regdst   = 1'b0;
    w_regwrite = 1'b0;
    w_branch   = 1'b0;
    w_memtoreg = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_jump     = 1'b0;
    w_jal      = 1'b0;
    w_jr       = 1'b0;
    w_illegal  = 1'b0;
    w_rs_used  = 1'b1;
    w_rt_used  = 1'b0;
    case (w_op)
      OP_R: begin
        w_alu_code = 4'd0;
        w_regdst   = 1'b1;
        w_rt_used  = 1'b1;
        // JR writes no register; it only redirects the PC
        if (w_funct == FUNCT_JR) begin
          w_jr       = 1'b1;
          w_regwrite = 1'b0;
        end else begin
          w_regwrite = 1'b1;
        end
      end
      OP_ADDI: begin
        w_alu_code = 4'd1;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_SLTI: begin
        w_alu_code = 4'd2;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_BEQ: begin
        w_alu_code = 4'd3;
        w_branch   = 1'b1;
        w_bt_code  = BT_EQ;
        w_rt_used  = 1'b1;
      end
      OP_LUI: begin
        w_alu_code = 4'd4;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
        w_rs_used  = 1'b0;
      end
      OP_ORI: begin
        w_alu_code = 4'd5;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_BNE: begin
        w_alu_code = 4'd6;
        w_branch   = 1'b1;
        w_bt_code  = BT_NE;
        w_rt_used  = 1'b1;
      end
      OP_LW: begin
        w_alu_code = 4'd7;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_memread  = 1'b1;
      end
      OP_SW: begin
        w_alu_code = 4'd8;
        w_alusrc   = 1'b1;
        w_memwrite = 1'b1;
        w_rt_used  = 1'b1;
      end
      OP_J: begin
        w_alu_code = 4'd9;
        w_jump     = 1'b1;
        w_rs_used  = 1'b0;
      end
      OP_BGT: begin
        w_alu_code = 4'd10;
        w_branch   = 1'b1;
        w_bt_code  = BT_GT;
        w_rt_used  = 1'b1;
      end
      OP_BGEZ: begin
        w_alu_code = 4'd12;
        w_branch   = 1'b1;
        w_bt_code  = BT_GEZ;
      end
      OP_JAL: begin
        w_alu_code = 4'd13;
        w_jump     = 1'b1;
        w_jal      = 1'b1;
        w_regwrite = 1'b1;
        w_rs_used  = 1'b0;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Load-use hazard; a taken branch/jump kills the ID instruction so no stall is needed
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_stall;
  logic w_bubble;

  assign w_rs_hit = w_rs_used && (ex_rt_i == w_rs);
  assign w_rt_hit = w_rt_used && (ex_rt_i == w_rt);
  assign w_stall  = instr_vld_i && ex_memread_i && (ex_rt_i != '0)
                    && (w_rs_hit || w_rt_hit) && !flush_i;
  assign w_bubble = flush_i || w_stall || !instr_vld_i;

  logic                r_vld;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic                r_alusrc;
  logic                r_regdst;
  logic                r_regwrite;
  logic                r_branch;
  logic                r_memtoreg;
  logic                r_memread;
  logic                r_memwrite;
  logic                r_jump;
  logic                r_jal;
  logic                r_jr;
  logic [BTYPE_W-1:0]  r_btype;
  logic                r_illegal;
  logic [CNT_W-1:0]    r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld      <= 1'b0;
      r_alu_op   <= '0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_regwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_jump     <= 1'b0;
      r_jal      <= 1'b0;
      r_jr       <= 1'b0;
      r_btype    <= '0;
      r_illegal  <= 1'b0;
    end else if (w_bubble) begin
      r_vld      <= 1'b0;
      r_alu_op   <= '0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_regwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_jump     <= 1'b0;
      r_jal      <= 1'b0;
      r_jr       <= 1'b0;
      r_btype    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_vld      <= 1'b1;
      r_alu_op   <= ALU_OP_W'(w_alu_code);
      r_alusrc   <= w_alusrc;
      r_regdst   <= w_regdst;
      r_regwrite <= w_regwrite;
      r_branch   <= w_branch;
      r_memtoreg <= w_memtoreg;
      r_memread  <= w_memread;
      r_memwrite <= w_memwrite;
      r_jump     <= w_jump;
      r_jal      <= w_jal;
      r_jr       <= w_jr;
      r_btype    <= BTYPE_W'(w_bt_code);
      r_illegal  <= w_illegal;
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_o     = w_stall;
  assign vld_o       = r_vld;
  assign alu_op_o    = r_alu_op;
  assign alusrc_o    = r_alusrc;
  assign regdst_o    = r_regdst;
  assign regwrite_o  = r_regwrite;
  assign branch_o    = r_branch;
  assign memtoreg_o  = r_memtoreg;
  assign memread_o   = r_memread;
  assign memwrite_o  = r_memwrite;
  assign jump_o      = r_jump;
  assign jal_o       = r_jal;
  assign jr_o        = r_jr;
  assign btype_o     = r_btype;
  assign illegal_o   = r_illegal;
  assign stall_cnt_o = r_stall_cnt;

endmodule
